secure_regfile: RTL and testbench

//  Parametrised successor to the single secure register: NUM_REGS-entry register file with
//  per-entry owner thread ID and sticky write lock. Thread 0 is the trusted root and

---
 rtl/secure_regfile.sv | 120 ++++++++++++
 tb/tb_secure_regfile.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/secure_regfile.sv
// secure_regfile: thread-tagged register file with per-entry owner and sticky write lock.
// Denied accesses return an error, bump a saturating counter and raise a sticky interrupt.
`default_nettype none

module secure_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8,
   parameter int TID_WIDTH  = 4,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_we,
   input  logic                        req_cfg,
   input  logic [$clog2(NUM_REGS)-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]       req_wdata,
   input  logic [TID_WIDTH-1:0]        req_tid,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_WIDTH-1:0]       rsp_rdata,
   output logic                        rsp_err,
   output logic [CNT_WIDTH-1:0]        viol_count,
   output logic                        viol_irq,
   input  logic                        irq_clr
);

   typedef enum logic [0:0] {IDLE = 1'b0, RESP = 1'b1} state_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  data_q  [NUM_REGS];
   logic [TID_WIDTH-1:0]   owner_q [NUM_REGS];
   logic [NUM_REGS-1:0]    lock_q;

   logic                   is_root;
   logic                   is_owner;
   logic                   allowed;
   logic                   accept;
   logic                   violation;
   logic [DATA_WIDTH-1:0]  read_val;

   always_comb begin
      is_root  = (req_tid == '0);
      is_owner = (req_tid == owner_q[req_addr]);
      read_val = '0;
      if (req_cfg) begin
         // Config space is root-only; a locked entry can no longer be reprogrammed.
         allowed = is_root && !(req_we && lock_q[req_addr]);
         read_val[TID_WIDTH:0] = {lock_q[req_addr], owner_q[req_addr]};
      end else begin
         allowed  = req_we ? (!lock_q[req_addr] && (is_root || is_owner))
                           : (is_root || is_owner);
         read_val = data_q[req_addr];
      end
      accept    = (state == IDLE) && req_valid;
      violation = accept && !allowed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         viol_count <= '0;
         viol_irq   <= 1'b0;
         lock_q     <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            data_q[i]  <= '0;
            owner_q[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= RESP;
                  req_ready <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !allowed;
                  rsp_rdata <= (allowed && !req_we) ? read_val : '0;
                  if (allowed && req_we) begin
                     if (req_cfg) begin
                        owner_q[req_addr] <= req_wdata[TID_WIDTH-1:0];
                        lock_q[req_addr]  <= lock_q[req_addr] | req_wdata[TID_WIDTH];
                     end else begin
                        data_q[req_addr] <= req_wdata;
                     end
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase

         if (violation && (viol_count != '1))
            viol_count <= viol_count + CNT_WIDTH'(1);

         // A new violation outranks a simultaneous clear request.
         if (violation)
            viol_irq <= 1'b1;
         else if (irq_clr)
            viol_irq <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_secure_regfile.sv
// tb_secure_regfile: randomized and directed checks of secure_regfile against a behavioural model.
`default_nettype none

module tb_secure_regfile;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 3;
   localparam int TW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we, req_cfg;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [TW-1:0] req_tid;
   logic          rsp_valid, rsp_ready, rsp_err, viol_irq, irq_clr;
   logic [DW-1:0] rsp_rdata;
   logic [CW-1:0] viol_count;

   secure_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .TID_WIDTH(TW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_cfg(req_cfg),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_tid(req_tid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .viol_count(viol_count), .viol_irq(viol_irq), .irq_clr(irq_clr)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state plus the single outstanding response.
   logic [DW-1:0] m_data  [NR];
   logic [TW-1:0] m_owner [NR];
   logic          m_lock  [NR];
   logic          m_busy;
   logic [DW-1:0] m_rdata;
   logic          m_err;
   int            m_cnt;
   logic          m_irq;

   function automatic logic permitted(input logic cfg, input logic we,
                                      input logic [AW-1:0] a, input logic [TW-1:0] tid);
      if (cfg) return (tid == 0) && !(we && m_lock[a]);
      if (we)  return !m_lock[a] && (tid == 0 || tid == m_owner[a]);
      return tid == 0 || tid == m_owner[a];
   endfunction

   function automatic logic [DW-1:0] readback(input logic cfg, input logic [AW-1:0] a);
      if (cfg) return DW'({m_lock[a], m_owner[a]});
      return m_data[a];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NR; i++) begin
            m_data[i]  <= '0;
            m_owner[i] <= '0;
            m_lock[i]  <= 1'b0;
         end
         m_busy  <= 1'b0;
         m_rdata <= '0;
         m_err   <= 1'b0;
         m_cnt   <= 0;
         m_irq   <= 1'b0;
      end else begin
         if (!m_busy && req_valid) begin
            m_busy  <= 1'b1;
            m_err   <= !permitted(req_cfg, req_we, req_addr, req_tid);
            m_rdata <= (permitted(req_cfg, req_we, req_addr, req_tid) && !req_we)
                       ? readback(req_cfg, req_addr) : '0;
            if (permitted(req_cfg, req_we, req_addr, req_tid)) begin
               if (req_we && req_cfg) begin
                  m_owner[req_addr] <= req_wdata[TW-1:0];
                  if (req_wdata[TW]) m_lock[req_addr] <= 1'b1;
               end else if (req_we) begin
                  m_data[req_addr] <= req_wdata;
               end
               if (irq_clr) m_irq <= 1'b0;
            end else begin
               m_cnt <= (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
               m_irq <= 1'b1;
            end
         end else begin
            if (m_busy && rsp_ready) m_busy <= 1'b0;
            if (irq_clr) m_irq <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("req_ready", req_ready, !m_busy);
      check("rsp_valid", rsp_valid, m_busy);
      check("viol_count", viol_count, m_cnt[CW-1:0]);
      check("viol_irq", viol_irq, m_irq);
      if (m_busy) begin
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("rsp_err", rsp_err, m_err);
      end
   end

   logic [DW-1:0] cap_rdata;
   logic          cap_err;

   // One full transaction: accept, optional back-pressure, consume.
   task automatic txn(input logic we, input logic cfg, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [TW-1:0] tid,
                      input int hold, input logic clr, input logic noisy);
      req_valid = 1'b1; req_we = we; req_cfg = cfg; req_addr = a; req_wdata = wd;
      req_tid = tid; rsp_ready = 1'b0; irq_clr = clr;
      @(posedge clk); #1;
      req_valid = 1'b0; irq_clr = 1'b0;
      cap_rdata = rsp_rdata; cap_err = rsp_err;
      for (int i = 0; i < hold; i++) begin
         if (noisy) begin
            req_valid = 1'($urandom); req_we = 1'($urandom); req_cfg = 1'($urandom);
            req_addr = AW'($urandom); req_wdata = $urandom; req_tid = 4'($urandom);
            irq_clr = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0; irq_clr = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 0; req_we = 0; req_cfg = 0; req_addr = '0;
      req_wdata = '0; req_tid = '0; rsp_ready = 0; irq_clr = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_count", viol_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Root write, then an unowned thread is refused.
      txn(1, 0, 3, 32'hDEADBEEF, 0, 0, 0, 0);
      txn(0, 0, 3, 0, 5, 1, 0, 0);
      check("t1_err", cap_err, 1'b1);
      check("t1_rdata", cap_rdata, 0);
      check("t1_count", viol_count, 1);
      check("t1_irq", viol_irq, 1'b1);

      // Ownership grants thread 5 access.
      txn(1, 1, 3, 32'h5, 0, 0, 0, 0);
      txn(1, 0, 3, 32'h1234, 5, 0, 0, 0);
      check("t2_wr_err", cap_err, 1'b0);
      txn(0, 0, 3, 0, 5, 0, 0, 0);
      check("t2_rdata", cap_rdata, 32'h1234);
      check("t2_err", cap_err, 1'b0);

      // Locking blocks every writer, root included, but reads still work.
      txn(1, 1, 3, 32'h15, 0, 0, 0, 0);
      txn(1, 0, 3, 32'hAAAA, 5, 0, 0, 0);
      check("t3_owner_wr_err", cap_err, 1'b1);
      txn(1, 0, 3, 32'hBBBB, 0, 0, 0, 0);
      check("t3_root_wr_err", cap_err, 1'b1);
      txn(1, 1, 3, 32'h2, 0, 0, 0, 0);
      check("t3_cfg_locked_err", cap_err, 1'b1);
      txn(0, 1, 3, 0, 0, 0, 0, 0);
      check("t3_cfg_read", cap_rdata, 32'h15);
      txn(0, 0, 3, 0, 5, 0, 0, 0);
      check("t3_rdata", cap_rdata, 32'h1234);
      check("t3_err", cap_err, 1'b0);
      check("t3_count", viol_count, 4);

      // Back-pressure: response held, second request ignored.
      req_valid = 1'b1; req_we = 0; req_cfg = 0; req_addr = 3; req_tid = 0;
      @(posedge clk); #1;
      req_tid = 5; req_addr = 1;
      repeat (5) begin
         @(posedge clk); #1;
         check("t4_req_ready", req_ready, 1'b0);
         check("t4_rdata_hold", rsp_rdata, 32'h1234);
      end
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("t4_count", viol_count, 4);

      // Randomized traffic across a few threads.
      for (int n = 0; n < 300; n++) begin
         rsp_ready = 1'($urandom); irq_clr = 1'($urandom);
         @(posedge clk); #1;
         txn(1'($urandom), ($urandom_range(0, 3) == 0), AW'($urandom),
             $urandom, TW'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom), 1'b1);
      end
      rsp_ready = 1'b0; irq_clr = 1'b0;

      // Counter saturation and interrupt clear precedence.
      for (int n = 0; n < (1 << CW) + 3; n++)
         txn(0, 1, AW'(n), 0, 7, 0, 0, 0);
      check("t5_saturated", viol_count, 8'hFF);
      txn(0, 1, 0, 0, 9, 0, 1, 0);
      check("t5_set_wins", viol_irq, 1'b1);
      irq_clr = 1'b1;
      @(posedge clk); #1;
      irq_clr = 1'b0;
      check("t5_cleared", viol_irq, 1'b0);

      // Reset while a response is pending.
      req_valid = 1'b1; req_we = 0; req_cfg = 0; req_addr = 3; req_tid = 0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("t6_pending", rsp_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rsp_valid", rsp_valid, 1'b0);
      check("t6_req_ready", req_ready, 1'b1);
      check("t6_count", viol_count, 0);
      check("t6_irq", viol_irq, 1'b0);
      check("t6_rdata", rsp_rdata, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      txn(0, 1, 3, 0, 0, 0, 0, 0);
      check("t6_cfg_cleared", cap_rdata, 0);
      txn(1, 0, 3, 32'h77, 0, 0, 0, 0);
      check("t6_unlocked_wr", cap_err, 1'b0);
      txn(0, 0, 3, 0, 0, 0, 0, 0);
      check("t6_data", cap_rdata, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
